spi_platform_designer_nios_cpu_mul_seq: RTL and testbench
=========================================================

SPI_PLATFORM_DESIGNER_NIOS_CPU_MUL_SEQ -- requirements
Module: spi_platform_designer_nios_cpu_mul_seq

Interface
REQ-001 SHALL have parameter CELL_LAT, default 1, meaning the number of enabled clock edges the multiplier cell needs from operands to valid partial products (legal 1..3).
REQ-002 SHALL have port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 SHALL have port reset_n  input  1  the asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  block idle and accepting a request.
REQ-006 SHALL have port req_op  input  2  operation code: 00 MUL (low 32), 01 MULXUU, 10 MULXSU (a signed, b unsigned), 11 MULXSS; the MULX codes return the high 32 bits.
REQ-007 SHALL have ports req_a and req_b  input  32 each  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port rsp_result  output  32  the result.
REQ-011 SHALL have ports E_src1 and E_src2  output  32 each  operands driven to the multiplier cell.
REQ-012 SHALL have port M_en  output  1  clock enable driven to the multiplier cell.
REQ-013 SHALL have ports M_mul_cell_p1, M_mul_cell_p2 and M_mul_cell_p3  input  32 each  the cell products src1[15:0]*src2[15:0], src1[15:0]*src2[31:16] and src1[31:16]*src2[15:0], all unsigned.

Function
REQ-014 SHALL implement the states IDLE, EXEC1, CAP1, EXEC2, CAP2 and DONE.
REQ-015 SHALL drive req_ready high only in IDLE and SHALL accept a request on an edge where req_valid and req_ready are both high, latching req_op, req_a and req_b and moving to EXEC1.
REQ-016 In EXEC1, SHALL drive E_src1=a, E_src2=b and M_en=1 for exactly CELL_LAT cycles, counted by a down-counter, and then move to CAP1.
REQ-017 In CAP1, SHALL hold M_en=0 and capture S = p1 + ((p2 + p3) << 16) as a 64-bit value, with the 33-bit sum p2+p3 computed without truncation.
REQ-018 From CAP1, SHALL go to DONE if op=MUL, with the result S[31:0]; otherwise SHALL go to EXEC2.
REQ-019 In EXEC2, SHALL drive E_src1={16'h0,a[31:16]}, E_src2={16'h0,b[31:16]} and M_en=1 for CELL_LAT cycles.
REQ-020 In CAP2, SHALL capture hh=p1 and form U = S + (hh << 32) mod 2^64, with uhi = U[63:32].
REQ-021 SHALL form the high result as uhi - (sa & a[31] ? b : 0) - (sb & b[31] ? a : 0) mod 2^32, where sa=1 for MULXSU and MULXSS and sb=1 for MULXSS only.
REQ-022 SHALL register the result into rsp_result and assert rsp_valid in DONE.
REQ-023 In DONE, SHALL hold rsp_valid and rsp_result stable until rsp_ready is high, then return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request in the DONE cycle.
REQ-025 Latency SHALL be CELL_LAT+2 cycles for MUL and 2*CELL_LAT+4 cycles for MULX, counted from the acceptance edge to the first cycle of rsp_valid.
REQ-026 SHALL drive M_en=0 in IDLE, CAP1, CAP2 and DONE.
REQ-027 SHALL drive E_src1 and E_src2 as 0 outside EXEC1 and EXEC2.
REQ-028 SHALL ignore req_valid, req_op, req_a and req_b outside IDLE.

Reset
REQ-029 While reset_n is low, SHALL force the state to IDLE, the counter to 0, and rsp_valid, rsp_result, M_en, E_src1 and E_src2 to 0.
REQ-030 SHALL force req_ready to 0 while reset_n is low; req_ready is registered and SHALL rise on the first clk edge after reset_n goes high.
REQ-031 Reset asserted in any state, mid-operation included, SHALL abort the operation with no response; the partial state SHALL NOT affect later operations.

Verification
REQ-032 CELL_LAT=1, MUL with a=0x0001_0003 and b=0x0002_0005 -> rsp_result=0x000B_000F, rsp_valid 3 cycles after acceptance, M_en high exactly 1 cycle.
REQ-033 MULXUU with a=b=0xFFFF_FFFF -> rsp_result=0xFFFF_FFFE after 6 cycles, M_en high in 2 separate 1-cycle pulses.
REQ-034 MULXSS with a=b=0xFFFF_FFFF -> rsp_result=0x0000_0000; MULXSU with the same operands -> rsp_result=0xFFFF_FFFF.
REQ-035 rsp_ready held low 5 cycles in DONE -> rsp_valid and rsp_result stable, req_ready=0, M_en=0; release -> IDLE next cycle and req_ready=1.
REQ-036 reset_n pulsed low during EXEC2 -> all outputs 0 immediately, no rsp_valid; the next request (MUL 7*6) -> rsp_result=0x0000_002A.
REQ-037 CELL_LAT=2 build, MUL 0x0001_0003*0x0002_0005 -> result 0x000B_000F after 4 cycles, M_en high exactly 2 consecutive cycles.

Source files
------------

// File: rtl/spi_platform_designer_nios_cpu_mul_seq.sv
// -----------------------------------------------------------------------------
// spi_platform_designer_nios_cpu_mul_seq
//
// Sequencer that builds 32x32 multiplies out of an external 16x16-based
// multiplier cell. The cell returns three unsigned partial products per pass:
//   p1 = src1[15:0]*src2[15:0], p2 = src1[15:0]*src2[31:16],
//   p3 = src1[31:16]*src2[15:0].
// A MUL needs one pass (low word only). The MULX variants need a second pass
// that feeds the high halves through the cell to obtain a[31:16]*b[31:16]. The
// signed variants then fix up the unsigned high word.
//
// Parameters:
//   CELL_LAT   enabled clock edges the cell needs from operands to products (1..3)
//
// Ports:
//   clk            single rising-edge clock
//   reset_n        asynchronous active-low reset
//   req_valid      request present
//   req_ready      registered, high only while idle
//   req_op         00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   req_a, req_b   operands
//   rsp_valid      result available (held until rsp_ready)
//   rsp_ready      consumer accepts the result
//   rsp_result     32-bit result
//   E_src1/E_src2  operands driven to the multiplier cell
//   M_en           clock enable for the multiplier cell
//   M_mul_cell_p1/p2/p3  partial products returned by the cell
// -----------------------------------------------------------------------------
module spi_platform_designer_nios_cpu_mul_seq #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] E_src1,
  output logic [31:0] E_src2,
  output logic        M_en,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    CAP1  = 3'd2,
    EXEC2 = 3'd3,
    CAP2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // Each exec phase runs while the counter walks from CELL_LAT-1 down to 0.
  localparam logic [1:0] LAT_LOAD = 2'(CELL_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [1:0]  cnt;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] s_hi;
  logic [31:0] uhi;

  logic        accept;
  logic [32:0] mid_sum;
  logic [63:0] s_full;
  logic [31:0] uhi_next;
  logic        sa;
  logic        sb;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] high_result;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // Cross terms are summed at 33 bits so the carry out of p2+p3 survives.
  assign mid_sum = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
  assign s_full  = {32'h0, M_mul_cell_p1} + ({31'h0, mid_sum} << 16);

  // Adding hh<<32 leaves the low word untouched, so only the high word of
  // the full unsigned product has to be kept.
  assign uhi_next = s_hi + M_mul_cell_p1;

  // Signed fix-up: a negative operand read as unsigned adds 2^32 times the
  // other operand, which only shows up in the high word.
  assign sa          = (op == OP_MULXSU) || (op == OP_MULXSS);
  assign sb          = (op == OP_MULXSS);
  assign corr_a      = (sa && a[31]) ? b : 32'h0;
  assign corr_b      = (sb && b[31]) ? a : 32'h0;
  assign high_result = uhi - corr_a - corr_b;

  always_comb begin
    next_state = state;
    E_src1     = 32'h0;
    E_src2     = 32'h0;
    M_en       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = EXEC1;
      end
      EXEC1: begin
        E_src1 = a;
        E_src2 = b;
        M_en   = 1'b1;
        if (cnt == 2'd0) next_state = CAP1;
      end
      CAP1: begin
        next_state = (op == OP_MUL) ? DONE : EXEC2;
      end
      EXEC2: begin
        E_src1 = {16'h0, a[31:16]};
        E_src2 = {16'h0, b[31:16]};
        M_en   = 1'b1;
        if (cnt == 2'd0) next_state = CAP2;
      end
      CAP2: begin
        // First cycle forms the unsigned high word, second applies the
        // signed corrections; splitting them keeps the adder chain short.
        if (cnt != 2'd0) next_state = DONE;
      end
      DONE: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      op         <= 2'b00;
      a          <= 32'h0;
      b          <= 32'h0;
      s_hi       <= 32'h0;
      uhi        <= 32'h0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'h0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            op  <= req_op;
            a   <= req_a;
            b   <= req_b;
            cnt <= LAT_LOAD;
          end
        end
        EXEC1, EXEC2: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
        end
        CAP1: begin
          s_hi <= s_full[63:32];
          if (op == OP_MUL) begin
            rsp_result <= s_full[31:0];
          end else begin
            cnt <= LAT_LOAD;
          end
        end
        CAP2: begin
          if (cnt == 2'd0) begin
            uhi <= uhi_next;
            cnt <= 2'd1;
          end else begin
            rsp_result <= high_result;
            cnt        <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_platform_designer_nios_cpu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_spi_platform_designer_nios_cpu_mul_seq
//
// Directed bench for the multiply sequencer. Two instances are built, one with
// CELL_LAT=1 and one with CELL_LAT=2, each paired with a behavioural model of
// the external multiplier cell whose pipeline depth matches its instance.
// Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_platform_designer_nios_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        rsp_ready;
  logic        sel;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        req_valid1, req_valid2;
  logic        req_ready1, req_ready2;
  logic        rsp_valid1, rsp_valid2;
  logic [31:0] rsp_result1, rsp_result2;
  logic [31:0] e_src1_1, e_src2_1, e_src1_2, e_src2_2;
  logic        m_en1, m_en2;

  logic [31:0] c1_p1, c1_p2, c1_p3;
  logic [31:0] c2a_p1, c2a_p2, c2a_p3;
  logic [31:0] c2_p1, c2_p2, c2_p3;

  logic        obs_req_ready, obs_rsp_valid, obs_m_en;
  logic [31:0] obs_rsp_result, obs_e_src1, obs_e_src2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign req_valid1 = req_valid & ~sel;
  assign req_valid2 = req_valid & sel;

  assign obs_req_ready  = sel ? req_ready2  : req_ready1;
  assign obs_rsp_valid  = sel ? rsp_valid2  : rsp_valid1;
  assign obs_rsp_result = sel ? rsp_result2 : rsp_result1;
  assign obs_m_en       = sel ? m_en2       : m_en1;
  assign obs_e_src1     = sel ? e_src1_2    : e_src1_1;
  assign obs_e_src2     = sel ? e_src2_2    : e_src2_1;

  spi_platform_designer_nios_cpu_mul_seq #(.CELL_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
    .E_src1(e_src1_1), .E_src2(e_src2_1), .M_en(m_en1),
    .M_mul_cell_p1(c1_p1), .M_mul_cell_p2(c1_p2), .M_mul_cell_p3(c1_p3)
  );

  spi_platform_designer_nios_cpu_mul_seq #(.CELL_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
    .E_src1(e_src1_2), .E_src2(e_src2_2), .M_en(m_en2),
    .M_mul_cell_p1(c2_p1), .M_mul_cell_p2(c2_p2), .M_mul_cell_p3(c2_p3)
  );

  // Single-stage cell model: products appear after one enabled edge.
  always @(posedge clk) begin
    if (m_en1) begin
      c1_p1 <= {16'h0, e_src1_1[15:0]}  * {16'h0, e_src2_1[15:0]};
      c1_p2 <= {16'h0, e_src1_1[15:0]}  * {16'h0, e_src2_1[31:16]};
      c1_p3 <= {16'h0, e_src1_1[31:16]} * {16'h0, e_src2_1[15:0]};
    end
  end

  // Two-stage cell model: products appear after two enabled edges.
  always @(posedge clk) begin
    if (m_en2) begin
      c2a_p1 <= {16'h0, e_src1_2[15:0]}  * {16'h0, e_src2_2[15:0]};
      c2a_p2 <= {16'h0, e_src1_2[15:0]}  * {16'h0, e_src2_2[31:16]};
      c2a_p3 <= {16'h0, e_src1_2[31:16]} * {16'h0, e_src2_2[15:0]};
      c2_p1  <= c2a_p1;
      c2_p2  <= c2a_p2;
      c2_p3  <= c2a_p3;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one request on the selected instance, follows it to DONE checking
  // cell operands, enable pulses and latency, holds the response for 'hold'
  // cycles and then retires it.
  task automatic applyStimulus(input logic use2, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int exp_lat,
                               input int exp_en, input int hold);
    int   cyc;
    int   en_cnt;
    int   pulses;
    logic prev;
    sel       = use2;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    checkOutput("req_ready_idle", obs_req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = ~op;
    req_a     = ~a;
    req_b     = b ^ 32'h5A5A_A5A5;
    cyc    = 1;
    en_cnt = 0;
    pulses = 0;
    prev   = 1'b0;
    while (!obs_rsp_valid && cyc < 40) begin
      if (obs_m_en) begin
        en_cnt++;
        if (!prev) pulses++;
        if (pulses == 1) begin
          checkOutput("e_src1_pass1", obs_e_src1, a);
          checkOutput("e_src2_pass1", obs_e_src2, b);
        end else begin
          checkOutput("e_src1_pass2", obs_e_src1, {16'h0, a[31:16]});
          checkOutput("e_src2_pass2", obs_e_src2, {16'h0, b[31:16]});
        end
      end else begin
        checkOutput("e_src_idle_zero", obs_e_src1 | obs_e_src2, 0);
      end
      prev = obs_m_en;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rsp_valid", obs_rsp_valid, 1);
    checkOutput("latency", cyc, exp_lat);
    checkOutput("result", obs_rsp_result, exp_res);
    checkOutput("m_en_cycles", en_cnt, exp_en);
    checkOutput("m_en_pulses", pulses, (op == 2'b00) ? 1 : 2);
    checkOutput("done_req_ready", obs_req_ready, 0);
    checkOutput("done_m_en", obs_m_en, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", obs_rsp_valid, 1);
      checkOutput("hold_result", obs_rsp_result, exp_res);
      checkOutput("hold_req_ready", obs_req_ready, 0);
      checkOutput("hold_m_en", obs_m_en, 0);
      checkOutput("hold_e_src", obs_e_src1 | obs_e_src2, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("retire_valid", obs_rsp_valid, 0);
    checkOutput("retire_req_ready", obs_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    sel       = 1'b0;
    req_op    = 2'b00;
    req_a     = 32'h0;
    req_b     = 32'h0;

    #2;
    checkOutput("rst_req_ready", req_ready1, 0);
    checkOutput("rst_rsp_valid", rsp_valid1, 0);
    checkOutput("rst_rsp_result", rsp_result1, 0);
    checkOutput("rst_m_en", m_en1, 0);
    checkOutput("rst_e_src", e_src1_1 | e_src2_1, 0);
    checkOutput("rst_req_ready2", req_ready2, 0);

    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("post_rst_ready_low", req_ready1, 0);
    @(posedge clk); #1;
    checkOutput("post_rst_ready_high", req_ready1, 1);
    checkOutput("post_rst_ready_high2", req_ready2, 1);

    $display("[TB] CELL_LAT=1 directed vectors");
    applyStimulus(1'b0, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 1, 0);
    applyStimulus(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6, 2, 5);
    applyStimulus(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6, 2, 0);
    applyStimulus(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 2, 0);
    applyStimulus(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1, 0);
    applyStimulus(1'b0, 2'b00, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 3, 1, 0);
    applyStimulus(1'b0, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 6, 2, 0);
    applyStimulus(1'b0, 2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 6, 2, 0);
    applyStimulus(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 6, 2, 0);

    $display("[TB] reset during second pass");
    sel       = 1'b0;
    req_op    = 2'b01;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("exec2_m_en", m_en1, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", rsp_valid1, 0);
    checkOutput("abort_rsp_result", rsp_result1, 0);
    checkOutput("abort_m_en", m_en1, 0);
    checkOutput("abort_e_src", e_src1_1 | e_src2_1, 0);
    checkOutput("abort_req_ready", req_ready1, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("abort_ready_low", req_ready1, 0);
    @(posedge clk); #1;
    checkOutput("abort_ready_high", req_ready1, 1);
    checkOutput("abort_no_rsp", rsp_valid1, 0);
    applyStimulus(1'b0, 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 3, 1, 0);

    $display("[TB] CELL_LAT=2 directed vectors");
    applyStimulus(1'b1, 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4, 2, 0);
    applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8, 4, 0);
    applyStimulus(1'b1, 2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 8, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
